ring_pe_nic: RTL and testbench
==============================

Name: ring_pe_nic

Overview:
- PE-side network interface for the bidirectional ring router. It is the far end of the router's PE port.
- Injects CPU-written packets into the router: drives router pesi/pedi, observes peri.
- Ejects packets the router delivers to the PE: observes peso/pedo, drives pero.
- Exposes a 4-register CPU window (two 64-bit channel buffers, two status words). One instance sits between each router and its processor.

Parameters:
- DATA_W, 64, packet width.
- VC_BIT, 63, packet bit selecting the virtual channel (0 = even-polarity slot, 1 = odd-polarity slot).
- HOP_MSB, 55, MSB of the 8-bit hop field [55:48]. Not modified by this block.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- addr  in  2  CPU register select: 0 = rx buffer, 1 = rx status, 2 = tx buffer, 3 = tx status.
- d_in  in  DATA_W  CPU write data.
- d_out  out  DATA_W  CPU read data, combinational from addr.
- nic_en  in  1  CPU access strobe.
- nic_wr_en  in  1  1 = write, 0 = read; qualified by nic_en.
- net_polarity  in  1  router polarity.
- net_si  in  1  router has a packet for the PE (router peso).
- net_di  in  DATA_W  ejected packet (router pedo).
- net_ri  out  1  NIC can accept (to router pero).
- net_so  out  1  NIC injecting (to router pesi).
- net_ro  in  1  router PE input ready (router peri).
- net_do  out  DATA_W  injected packet (to router pedi).

Behaviour:
- Reset values: rx_full=0, tx_full=0, rx_buf=0, tx_buf=0, net_so=0, net_ri=1, net_do=0, counters=0. Reset wins over every concurrent event and aborts a pending injection.
- Receive state machine, states RX_EMPTY / RX_FULL.
  - net_ri = ~rx_full.
  - In RX_EMPTY, if net_si=1 at a posedge: rx_buf <= net_di, go to RX_FULL. Capture does not depend on polarity.
  - In RX_FULL, net_si is ignored.
  - CPU read of addr 0 (nic_en=1, nic_wr_en=0) returns rx_buf in the same cycle; at that edge go to RX_EMPTY.
  - Read of addr 0 while RX_EMPTY returns stale rx_buf with no state change.
  - Read in RX_FULL while net_si=1: drain only. The new packet is taken on a later cycle, since net_ri was 0.
- Transmit state machine, states TX_EMPTY / TX_WAIT.
  - CPU write of addr 2 in TX_EMPTY: tx_buf <= d_in, go to TX_WAIT.
  - Write of addr 2 in TX_WAIT is dropped; tx_buf is unchanged.
  - In TX_WAIT, net_so = net_ro && (net_polarity == tx_buf[VC_BIT]), combinational, and net_so=0 otherwise.
  - At an edge with net_so=1: go to TX_EMPTY.
  - net_do = tx_buf at all times and stays stable until the next accepted write. This covers the router's one-cycle-delayed capture.
  - A write to addr 2 in the cycle net_so=1 is dropped, because state is still TX_WAIT.
- Status reads:
  - addr 1: bit0 = rx_full.
  - addr 3: bit0 = tx_full (TX_WAIT).
  - All other bits 0 unless NIC_STATS_EN is defined.
- Writes to addr 0, 1 and 3 are ignored.
- Latency:
  - Ejection: one edge from net_si to rx status = 1.
  - Injection: from one cycle after the write until the first cycle where polarity matches and net_ro=1. Worst case with net_ro=1 is 2 cycles.
- Hop field is passed through untouched in both directions.

Optional Feature:
- Macro NIC_STATS_EN.
- Defined:
  - 16-bit rx_cnt increments on each RX capture; tx_cnt increments on each net_so=1 edge. Both wrap 0xFFFF -> 0x0000 and clear on reset.
  - rx_cnt is returned on addr 1 bits [31:16]; tx_cnt on addr 3 bits [31:16].
- Undefined: no counters; those bits read 0.

Test Plan:
- Reset, then read addr 1 and addr 3 -> d_out=0. net_ri=1, net_so=0, net_do=0.
- Write addr 2 = 0x8003_0000_0000_00AA with net_polarity toggling and net_ro=1:
  - net_so pulses for exactly one cycle, in the cycle net_polarity=1.
  - net_do = 0x8003_0000_0000_00AA.
  - addr 3 bit0 then reads 0.
- Write addr 2 twice back-to-back (0x11, then 0x22) with net_ro=0 -> tx_buf stays 0x11. Raise net_ro with net_polarity=0 -> one net_so pulse carrying 0x11.
- Inbound ejection:
  - net_si=1 with net_di=0x4000_0000_0000_BEEF -> next cycle net_ri=0 and addr 1 bit0=1.
  - A second net_si with 0x1234 is ignored.
  - Read addr 0 -> 0x...BEEF; next cycle net_ri=1.
- Assert reset while in TX_WAIT and RX_FULL -> next cycle both status bits are 0, net_so=0, and no injection occurs afterwards.
- With NIC_STATS_EN: 3 ejections and 2 injections -> addr 1 [31:16]=3, addr 3 [31:16]=2. Preload 0xFFFF plus one event -> 0.

Source files
------------

// File: rtl/ring_pe_nic_if.sv
// Bundle between a ring PE-side NIC and its environment: the CPU register
// window plus the router PE port (ejection and injection handshakes).
// master = CPU + router side, slave = NIC.
interface ring_pe_nic_if #(
    parameter int DATA_W = 64
);
    // CPU register window
    logic [1:0]        addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out;
    logic              nic_en;
    logic              nic_wr_en;
    // router PE port
    logic              net_polarity;
    logic              net_si;
    logic [DATA_W-1:0] net_di;
    logic              net_ri;
    logic              net_so;
    logic              net_ro;
    logic [DATA_W-1:0] net_do;

    modport master (
        output addr, d_in, nic_en, nic_wr_en,
        output net_polarity, net_si, net_di, net_ro,
        input  d_out, net_ri, net_so, net_do
    );

    modport slave (
        input  addr, d_in, nic_en, nic_wr_en,
        input  net_polarity, net_si, net_di, net_ro,
        output d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/ring_pe_nic.sv
// PE-side network interface for the bidirectional ring router.
// One-packet receive buffer (ejection) and one-packet transmit buffer
// (injection) exposed to the CPU as a 4-register window:
//   0 = rx buffer, 1 = rx status, 2 = tx buffer, 3 = tx status.
// Optional macro NIC_STATS_EN adds 16-bit rx/tx packet counters that read
// back on status bits [31:16].
module ring_pe_nic #(
    parameter int DATA_W  = 64,
    parameter int VC_BIT  = 63,
    parameter int HOP_MSB = 55
) (
    input  logic         clk,
    input  logic         reset,
    ring_pe_nic_if.slave bus
);
    typedef enum logic { RX_EMPTY = 1'b0, RX_FULL = 1'b1 } rx_state_t;
    typedef enum logic { TX_EMPTY = 1'b0, TX_WAIT = 1'b1 } tx_state_t;

    localparam int HOP_LSB = HOP_MSB - 7;

    rx_state_t         rx_st;
    tx_state_t         tx_st;
    logic [DATA_W-1:0] rx_buf;
    logic [DATA_W-1:0] tx_buf;
    logic              rx_full;
    logic              tx_full;
    logic              rd_rx;
    logic              wr_tx;
    logic              inject;
    logic [DATA_W-1:0] rx_stat;
    logic [DATA_W-1:0] tx_stat;

    assign rx_full = (rx_st == RX_FULL);
    assign tx_full = (tx_st == TX_WAIT);
    assign rd_rx   = bus.nic_en && !bus.nic_wr_en && (bus.addr == 2'd0);
    assign wr_tx   = bus.nic_en &&  bus.nic_wr_en && (bus.addr == 2'd2);

    // Inject only on the slot whose polarity matches the packet's VC bit;
    // gated by reset so a pending packet is never handed over while resetting.
    assign inject  = !reset && tx_full && bus.net_ro &&
                     (bus.net_polarity == tx_buf[VC_BIT]);

    assign bus.net_so = inject;
    assign bus.net_ri = !rx_full;
    // Hop field travels through untouched; the router owns its update.
    assign bus.net_do = {tx_buf[DATA_W-1:HOP_MSB+1], tx_buf[HOP_MSB:HOP_LSB],
                         tx_buf[HOP_LSB-1:0]};

    // Receive FSM: capture one ejected packet, hold until the CPU drains it.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_st  <= RX_EMPTY;
            rx_buf <= '0;
        end else begin
            case (rx_st)
                RX_EMPTY: if (bus.net_si) begin
                    rx_buf <= {bus.net_di[DATA_W-1:HOP_MSB+1],
                               bus.net_di[HOP_MSB:HOP_LSB],
                               bus.net_di[HOP_LSB-1:0]};
                    rx_st  <= RX_FULL;
                end
                RX_FULL:  if (rd_rx) rx_st <= RX_EMPTY;
                default:  rx_st <= RX_EMPTY;
            endcase
        end
    end

    // Transmit FSM: accept one CPU packet, hold it until the router takes it.
    // Writes while a packet is pending are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st  <= TX_EMPTY;
            tx_buf <= '0;
        end else begin
            case (tx_st)
                TX_EMPTY: if (wr_tx) begin
                    tx_buf <= bus.d_in;
                    tx_st  <= TX_WAIT;
                end
                TX_WAIT:  if (inject) tx_st <= TX_EMPTY;
                default:  tx_st <= TX_EMPTY;
            endcase
        end
    end

`ifdef NIC_STATS_EN
    logic [15:0] rx_cnt;
    logic [15:0] tx_cnt;

    // Packet counters, free-running with natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt <= '0;
            tx_cnt <= '0;
        end else begin
            if (!rx_full && bus.net_si) rx_cnt <= rx_cnt + 16'd1;
            if (inject)                 tx_cnt <= tx_cnt + 16'd1;
        end
    end
`endif

    // Status words: bit0 = buffer occupied, [31:16] = counter when enabled.
    always_comb begin
        rx_stat    = '0;
        tx_stat    = '0;
        rx_stat[0] = rx_full;
        tx_stat[0] = tx_full;
`ifdef NIC_STATS_EN
        rx_stat[31:16] = rx_cnt;
        tx_stat[31:16] = tx_cnt;
`endif
    end

    // CPU read mux, combinational from addr.
    always_comb begin
        case (bus.addr)
            2'd0:    bus.d_out = rx_buf;
            2'd1:    bus.d_out = rx_stat;
            2'd2:    bus.d_out = tx_buf;
            default: bus.d_out = tx_stat;
        endcase
    end
endmodule

// File: tb/tb_ring_pe_nic.sv
// Testbench for ring_pe_nic: directed scenarios plus random traffic, all
// checked against a packet-level model (one rx slot, one tx slot).
module tb_ring_pe_nic;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ring_pe_nic_if #(.DATA_W(64)) bus();
    ring_pe_nic dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    // model: does the rx/tx slot hold a packet, and which
    bit          m_rx_has;
    bit   [63:0] m_rx_pkt;
    bit          m_tx_has;
    bit   [63:0] m_tx_pkt;
    int          m_rx_n;
    int          m_tx_n;

    // last observed outputs, for directed checks against constants
    logic [63:0] o_dout, o_do;
    logic        o_ri, o_so;
    int          so_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rx_has = 0; m_rx_pkt = '0;
        m_tx_has = 0; m_tx_pkt = '0;
        m_rx_n = 0;   m_tx_n = 0;
    endtask

    function automatic logic [63:0] stat(input bit full, input int cnt);
        logic [63:0] s;
        s = '0;
        s[0] = full;
`ifdef NIC_STATS_EN
        s[31:16] = cnt[15:0];
`endif
        return s;
    endfunction

    // One cycle: drive at negedge, check outputs, advance the model to the posedge.
    task automatic step(input logic [1:0] a, input logic [63:0] d, input logic en,
                        input logic wr, input logic pol, input logic si,
                        input logic [63:0] di, input logic ro, input logic rst);
        logic [63:0] e_dout;
        logic        e_so;
        @(negedge clk);
        bus.addr = a; bus.d_in = d; bus.nic_en = en; bus.nic_wr_en = wr;
        bus.net_polarity = pol; bus.net_si = si; bus.net_di = di; bus.net_ro = ro;
        reset = rst;
        #1;
        e_so = !rst && m_tx_has && ro && (pol == m_tx_pkt[63]);
        case (a)
            2'd0: e_dout = m_rx_pkt;
            2'd1: e_dout = stat(m_rx_has, m_rx_n);
            2'd2: e_dout = m_tx_pkt;
            default: e_dout = stat(m_tx_has, m_tx_n);
        endcase
        o_dout = bus.d_out; o_do = bus.net_do; o_ri = bus.net_ri; o_so = bus.net_so;
        chk("d_out",  o_dout, e_dout);
        chk("net_ri", {63'd0, o_ri}, {63'd0, !m_rx_has});
        chk("net_so", {63'd0, o_so}, {63'd0, e_so});
        chk("net_do", o_do, m_tx_pkt);
        if (o_so === 1'b1) so_seen++;
        if (rst) model_reset();
        else begin
            if (!m_rx_has && si) begin
                m_rx_has = 1; m_rx_pkt = di; m_rx_n = (m_rx_n + 1) % 65536;
            end else if (m_rx_has && en && !wr && a == 2'd0) m_rx_has = 0;
            if (e_so) begin
                m_tx_has = 0; m_tx_n = (m_tx_n + 1) % 65536;
            end else if (!m_tx_has && en && wr && a == 2'd2) begin
                m_tx_has = 1; m_tx_pkt = d;
            end
        end
    endtask

    task automatic idle(input logic [1:0] a, input logic pol, input logic ro);
        step(a, '0, 1'b0, 1'b0, pol, 1'b0, '0, ro, 1'b0);
    endtask

    task automatic rd(input logic [1:0] a);
        step(a, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr_tx(input logic [63:0] d, input logic pol, input logic ro);
        step(2'd2, d, 1'b1, 1'b1, pol, 1'b0, '0, ro, 1'b0);
    endtask

    task automatic eject(input logic [63:0] di);
        step(2'd1, '0, 1'b0, 1'b0, 1'b0, 1'b1, di, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(2'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int s0;
        logic pol;
        // bring-up reset: DUT state is unknown until the first edge, so no checks
        bus.addr = 0; bus.d_in = 0; bus.nic_en = 0; bus.nic_wr_en = 0;
        bus.net_polarity = 0; bus.net_si = 0; bus.net_di = 0; bus.net_ro = 0;
        reset = 1;
        repeat (2) @(posedge clk);
        model_reset();

        // reset state
        rd(2'd1); chk("rst_rx_stat", o_dout, 64'd0);
        rd(2'd3); chk("rst_tx_stat", o_dout, 64'd0);
        chk("rst_ri_so_do", {o_ri, o_so, o_do}, {1'b1, 1'b0, 64'd0});

        // odd-VC packet, polarity toggling, router ready
        s0 = so_seen;
        wr_tx(64'h8003_0000_0000_00AA, 1'b1, 1'b1);
        pol = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle(2'd3, pol, 1'b1);
            if (o_so) chk("so_pol1", {63'd0, pol}, 64'd1);
            pol = ~pol;
        end
        chk("so_once", so_seen - s0, 1);
        chk("do_hold", o_do, 64'h8003_0000_0000_00AA);
        rd(2'd3); chk("tx_cleared", o_dout, 64'd0);

        // back-to-back writes while blocked: second is dropped
        wr_tx(64'h11, 1'b0, 1'b0);
        wr_tx(64'h22, 1'b0, 1'b0);
        rd(2'd2); chk("tx_keep", o_dout, 64'h11);
        s0 = so_seen;
        idle(2'd3, 1'b0, 1'b1);
        chk("inj_11", {o_so, o_do}, {1'b1, 64'h11});
        idle(2'd3, 1'b0, 1'b1);
        chk("inj_once", so_seen - s0, 1);

        // ejection
        eject(64'h4000_0000_0000_BEEF);
        rd(2'd1); chk("rx_full", {o_ri, o_dout[0]}, 2'b01);
        eject(64'h1234);
        rd(2'd0); chk("rx_data", o_dout, 64'h4000_0000_0000_BEEF);
        idle(2'd1, 1'b0, 1'b0); chk("rx_drained", {63'd0, o_ri}, 64'd1);

        // reset with both slots occupied
        wr_tx(64'h8000_0000_0000_0001, 1'b0, 1'b0);
        eject(64'h55);
        do_reset();
        rd(2'd1); chk("rst2_rx", o_dout, 64'd0);
        rd(2'd3); chk("rst2_tx", o_dout, 64'd0);
        s0 = so_seen;
        for (int i = 0; i < 4; i++) idle(2'd3, i[0], 1'b1);
        chk("rst2_no_inj", so_seen - s0, 0);

`ifdef NIC_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            eject(64'(i + 7));
            rd(2'd0);
        end
        wr_tx(64'h1, 1'b0, 1'b0); idle(2'd3, 1'b0, 1'b1);
        wr_tx(64'h2, 1'b0, 1'b0); idle(2'd3, 1'b0, 1'b1);
        rd(2'd1); chk("rx_cnt3", {48'd0, o_dout[31:16]}, 64'd3);
        rd(2'd3); chk("tx_cnt2", {48'd0, o_dout[31:16]}, 64'd2);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] d, di;
            d  = {$urandom, $urandom};
            di = {$urandom, $urandom};
            step(2'($urandom_range(0, 3)), d, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), di, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
